// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite animator slice.
package sprite_pkg;

    // Encoding doubles as the sprite-sheet row.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK_R = 2'd1,
        WALK_L = 2'd2,
        JUMP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KEY_NONE,
        KEY_LEFT,
        KEY_RIGHT,
        KEY_JUMP
    } key_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_W = 8'h1A;

    localparam int SHEET_COLS = 4;
    localparam int CELL_W     = 32;
    localparam int CELL_H     = 52;

    function automatic key_t decode_key(input logic [7:0] kc);
        case (kc)
            KEY_A:   return KEY_LEFT;
            KEY_D:   return KEY_RIGHT;
            KEY_W:   return KEY_JUMP;
            default: return KEY_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sprite_animator_if.sv
// Keyboard/vsync inputs and colour-mapper outputs of the sprite animator.
interface sprite_animator_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] shape_x;
    logic [9:0] shape_y;
    logic [3:0] sel;
    logic       facing;

    modport master (
        output frame_clk, keycode,
        input  shape_x, shape_y, sel, facing
    );

    modport slave (
        input  frame_clk, keycode,
        output shape_x, shape_y, sel, facing
    );
endinterface

// File: rtl/frame_tick.sv
// Rising-edge detector on the vsync level; one Clk-wide tick per frame.
module frame_tick (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);
    logic frame_clk_d;

    // Delay register resets high so a frame_clk already high at release is not a tick.
    always_ff @(posedge Clk) begin
        if (!Reset_n) frame_clk_d <= 1'b1;
        else          frame_clk_d <= frame_clk;
    end

    assign tick = frame_clk & ~frame_clk_d;
endmodule

// File: rtl/sprite_animator.sv
// Per-frame sprite movement, jump physics and sheet-cell selection.
//  state  | meaning
//  IDLE   | standing, row 0
//  WALK_R | walking right, row 1
//  WALK_L | walking left, row 2
//  JUMP   | airborne, row 3, column follows vertical speed
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SPRITE_W = 32,
    parameter int GROUND_Y = 400,
    parameter int INIT_X   = 304,
    parameter int STEP_X   = 2,
    parameter int JUMP_V   = 10,
    parameter int GRAVITY  = 1,
    parameter int ANIM_DIV = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    sprite_animator_if.slave bus
);
    localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(ANIM_DIV - 1);
    localparam logic [9:0]        X_MAX     = 10'(SCREEN_W - SPRITE_W);
    localparam logic [9:0]        X_LIM     = 10'(SCREEN_W - SPRITE_W - STEP_X);
    localparam logic [9:0]        STEP      = 10'(STEP_X);
    localparam logic [9:0]        X_RESET   = 10'(INIT_X);
    localparam logic signed [10:0] Y_GND    = 11'(GROUND_Y);
    localparam logic signed [11:0] Y_GND12  = 12'(GROUND_Y);
    localparam logic signed [7:0] VY_LAUNCH = 8'(-JUMP_V);
    localparam logic signed [7:0] GRAV      = 8'(GRAVITY);
    localparam logic signed [7:0] HALF      = 8'(JUMP_V / 2);
    localparam logic signed [7:0] NEG_HALF  = 8'(-(JUMP_V / 2));

    logic tick;
    key_t key;

    state_t              state, state_n;
    logic [9:0]          x_q, x_n;
    logic signed [10:0]  y_q, y_n;
    logic signed [7:0]   vy_q, vy_n, vy_cur;
    logic signed [11:0]  y_sum;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [1:0]          col_q, col_n, col_show;
    logic                facing_q, facing_n;
    logic [3:0]          sel_q, sel_n;

    frame_tick u_tick (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (bus.frame_clk),
        .tick      (tick)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Position, physics and animation registers; next values already hold off-tick.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            x_q      <= X_RESET;
            y_q      <= Y_GND;
            vy_q     <= '0;
            cnt_q    <= '0;
            col_q    <= '0;
            facing_q <= 1'b1;
            sel_q    <= '0;
        end else begin
            x_q      <= x_n;
            y_q      <= y_n;
            vy_q     <= vy_n;
            cnt_q    <= cnt_n;
            col_q    <= col_n;
            facing_q <= facing_n;
            sel_q    <= sel_n;
        end
    end

    // Next-state, motion and sheet-cell selection, evaluated only on a frame tick.
    always_comb begin
        key      = decode_key(bus.keycode);
        state_n  = state;
        x_n      = x_q;
        y_n      = y_q;
        vy_n     = vy_q;
        cnt_n    = cnt_q;
        col_n    = col_q;
        facing_n = facing_q;
        sel_n    = sel_q;
        vy_cur   = vy_q;
        y_sum    = '0;
        col_show = col_q;

        if (tick) begin
            if (state != JUMP) begin
                case (key)
                    KEY_JUMP:  state_n = JUMP;
                    KEY_RIGHT: state_n = WALK_R;
                    KEY_LEFT:  state_n = WALK_L;
                    default:   state_n = IDLE;
                endcase
            end

            if (key == KEY_RIGHT) begin
                facing_n = 1'b1;
                x_n      = (x_q >= X_LIM) ? X_MAX : x_q + STEP;
            end else if (key == KEY_LEFT) begin
                facing_n = 1'b0;
                x_n      = (x_q < STEP) ? '0 : x_q - STEP;
            end

            if (state_n == JUMP) begin
                vy_cur = (state == JUMP) ? vy_q : VY_LAUNCH;
                y_sum  = {y_q[10], y_q} + {{4{vy_cur[7]}}, vy_cur};
                vy_n   = vy_cur + GRAV;
                if (y_sum >= Y_GND12 && vy_cur > 8'sd0) begin
                    y_n     = Y_GND;
                    vy_n    = '0;
                    state_n = IDLE;
                end else begin
                    y_n = y_sum[11] ? '0 : y_sum[10:0];
                end
            end

            if (state_n == JUMP) begin
                if (vy_n < NEG_HALF)   col_show = 2'd0;
                else if (vy_n < 8'sd0) col_show = 2'd1;
                else if (vy_n < HALF)  col_show = 2'd2;
                else                   col_show = 2'd3;
                col_n = col_show;
                cnt_n = '0;
            end else if (state_n != state) begin
                col_show = 2'd0;
                col_n    = 2'd0;
                cnt_n    = '0;
            end else begin
                // The displayed column is the one held at the start of this tick,
                // so each column is shown for a full ANIM_DIV ticks.
                col_show = col_q;
                if (cnt_q == CNT_MAX) begin
                    cnt_n = '0;
                    col_n = col_q + 2'd1;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            sel_n = {state_n, col_show};
        end
    end

    assign bus.shape_x = x_q;
    assign bus.shape_y = y_q[9:0];
    assign bus.sel     = sel_q;
    assign bus.facing  = facing_q;
endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: reset, idle animation, walking, clamps,
// jump arc, mid-jump reset and vsync held high.
module tb_sprite_animator;
    logic Clk;
    logic Reset_n;
    int   n_checks;
    int   n_fail;

    sprite_animator_if bus0 ();
    sprite_animator_if bus1 ();

    sprite_animator dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus0)
    );

    // Second instance starting at an odd x, to reach the left edge below one step.
    sprite_animator #(.INIT_X(5)) dut_odd (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic do_reset();
        @(negedge Clk);
        Reset_n        = 1'b0;
        bus0.frame_clk = 1'b0;
        bus1.frame_clk = 1'b0;
        bus0.keycode   = 8'h00;
        bus1.keycode   = 8'h00;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic tick_once();
        @(negedge Clk);
        bus0.frame_clk = 1'b1;
        bus1.frame_clk = 1'b1;
        @(negedge Clk);
        bus0.frame_clk = 1'b0;
        bus1.frame_clk = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus0.shape_x !== 10'd304) begin
            n_fail++;
            $display("FAIL reset_x: got %0d want 304", bus0.shape_x);
        end
        n_checks++;
        if (bus0.shape_y !== 10'd400) begin
            n_fail++;
            $display("FAIL reset_y: got %0d want 400", bus0.shape_y);
        end
        n_checks++;
        if (bus0.sel !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_sel: got %h want 0", bus0.sel);
        end
        n_checks++;
        if (bus0.facing !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_facing: got %b want 1", bus0.facing);
        end
        n_checks++;
        if (bus1.shape_x !== 10'd5) begin
            n_fail++;
            $display("FAIL reset_x_odd: got %0d want 5", bus1.shape_x);
        end
    endtask

    task automatic test_idle_anim();
        logic [3:0] exp_sel;
        do_reset();
        for (int t = 1; t <= 20; t++) begin
            tick_once();
            exp_sel = (t <= 8) ? 4'h0 : (t <= 16) ? 4'h1 : 4'h2;
            n_checks++;
            if (bus0.sel !== exp_sel) begin
                n_fail++;
                $display("FAIL idle_sel tick %0d: got %h want %h", t, bus0.sel, exp_sel);
            end
            n_checks++;
            if (bus0.shape_x !== 10'd304 || bus0.shape_y !== 10'd400) begin
                n_fail++;
                $display("FAIL idle_pos tick %0d: got %0d,%0d want 304,400",
                         t, bus0.shape_x, bus0.shape_y);
            end
        end
    endtask

    task automatic test_walk();
        int exp_x;
        do_reset();
        bus0.keycode = 8'h07;
        for (int t = 1; t <= 3; t++) begin
            tick_once();
            exp_x = 304 + 2 * t;
            n_checks++;
            if (bus0.shape_x !== 10'(exp_x)) begin
                n_fail++;
                $display("FAIL walk_r_x tick %0d: got %0d want %0d", t, bus0.shape_x, exp_x);
            end
        end
        n_checks++;
        if (bus0.sel !== 4'h4 || bus0.facing !== 1'b1) begin
            n_fail++;
            $display("FAIL walk_r_sel: got sel %h facing %b want 4 1", bus0.sel, bus0.facing);
        end
        bus0.keycode = 8'h04;
        tick_once();
        n_checks++;
        if (bus0.shape_x !== 10'd308) begin
            n_fail++;
            $display("FAIL walk_l_x: got %0d want 308", bus0.shape_x);
        end
        n_checks++;
        if (bus0.sel !== 4'h8 || bus0.facing !== 1'b0) begin
            n_fail++;
            $display("FAIL walk_l_sel: got sel %h facing %b want 8 0", bus0.sel, bus0.facing);
        end
    endtask

    task automatic test_right_clamp();
        bus0.keycode = 8'h07;
        repeat (149) tick_once();
        n_checks++;
        if (bus0.shape_x !== 10'd606) begin
            n_fail++;
            $display("FAIL clamp_r_start: got %0d want 606", bus0.shape_x);
        end
        for (int t = 1; t <= 3; t++) begin
            tick_once();
            n_checks++;
            if (bus0.shape_x !== 10'd608) begin
                n_fail++;
                $display("FAIL clamp_r tick %0d: got %0d want 608", t, bus0.shape_x);
            end
        end
    endtask

    task automatic test_left_clamp();
        int exp_x [4] = '{3, 1, 0, 0};
        do_reset();
        bus1.keycode = 8'h04;
        for (int t = 0; t < 4; t++) begin
            tick_once();
            n_checks++;
            if (bus1.shape_x !== 10'(exp_x[t])) begin
                n_fail++;
                $display("FAIL clamp_l tick %0d: got %0d want %0d", t + 1, bus1.shape_x, exp_x[t]);
            end
        end
        bus1.keycode = 8'h00;
    endtask

    task automatic test_jump();
        int         exp_y   [21] = '{390, 381, 373, 366, 360, 355, 351, 348, 346, 345, 345,
                                     346, 348, 351, 355, 360, 366, 373, 381, 390, 400};
        logic [3:0] exp_sel [21] = '{4'hC, 4'hC, 4'hC, 4'hC, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD,
                                     4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF,
                                     4'hF, 4'hF, 4'h0};
        do_reset();
        bus0.keycode = 8'h1A;
        for (int t = 0; t < 21; t++) begin
            tick_once();
            bus0.keycode = 8'h00;
            n_checks++;
            if (bus0.shape_y !== 10'(exp_y[t])) begin
                n_fail++;
                $display("FAIL jump_y tick %0d: got %0d want %0d", t + 1, bus0.shape_y, exp_y[t]);
            end
            n_checks++;
            if (bus0.sel !== exp_sel[t]) begin
                n_fail++;
                $display("FAIL jump_sel tick %0d: got %h want %h", t + 1, bus0.sel, exp_sel[t]);
            end
        end
        tick_once();
        n_checks++;
        if (bus0.shape_y !== 10'd400 || bus0.sel !== 4'h0 || bus0.shape_x !== 10'd304) begin
            n_fail++;
            $display("FAIL jump_rest: got y %0d sel %h x %0d want 400 0 304",
                     bus0.shape_y, bus0.sel, bus0.shape_x);
        end
    endtask

    task automatic test_reset_mid_jump();
        do_reset();
        bus0.keycode = 8'h04;
        tick_once();
        bus0.keycode = 8'h1A;
        tick_once();
        bus0.keycode = 8'h00;
        repeat (4) tick_once();
        n_checks++;
        if (bus0.shape_y !== 10'd360 || bus0.shape_x !== 10'd302 || bus0.facing !== 1'b0) begin
            n_fail++;
            $display("FAIL midjump_pre: got y %0d x %0d facing %b want 360 302 0",
                     bus0.shape_y, bus0.shape_x, bus0.facing);
        end
        @(negedge Clk);
        bus0.frame_clk = 1'b1;
        bus1.frame_clk = 1'b1;
        Reset_n        = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        n_checks++;
        if (bus0.shape_y !== 10'd400 || bus0.sel !== 4'h0 || bus0.facing !== 1'b1 ||
            bus0.shape_x !== 10'd304) begin
            n_fail++;
            $display("FAIL midjump_reset: got y %0d sel %h facing %b x %0d want 400 0 1 304",
                     bus0.shape_y, bus0.sel, bus0.facing, bus0.shape_x);
        end
        bus0.keycode = 8'h07;
        repeat (5) @(negedge Clk);
        n_checks++;
        if (bus0.shape_x !== 10'd304 || bus0.sel !== 4'h0) begin
            n_fail++;
            $display("FAIL midjump_release_hold: got x %0d sel %h want 304 0",
                     bus0.shape_x, bus0.sel);
        end
        bus0.frame_clk = 1'b0;
        bus1.frame_clk = 1'b0;
        tick_once();
        n_checks++;
        if (bus0.shape_x !== 10'd306 || bus0.sel !== 4'h4) begin
            n_fail++;
            $display("FAIL midjump_next_tick: got x %0d sel %h want 306 4",
                     bus0.shape_x, bus0.sel);
        end
    endtask

    task automatic test_hold_high();
        bus0.keycode = 8'h07;
        @(negedge Clk);
        bus0.frame_clk = 1'b1;
        bus1.frame_clk = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge Clk);
            n_checks++;
            if (bus0.shape_x !== 10'd308 || bus0.sel !== 4'h4 || bus0.shape_y !== 10'd400) begin
                n_fail++;
                $display("FAIL hold_high cycle %0d: got x %0d sel %h y %0d want 308 4 400",
                         c, bus0.shape_x, bus0.sel, bus0.shape_y);
            end
        end
        bus0.frame_clk = 1'b0;
        bus1.frame_clk = 1'b0;
        bus0.keycode   = 8'h00;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        Reset_n        = 1'b0;
        bus0.frame_clk = 1'b0;
        bus1.frame_clk = 1'b0;
        bus0.keycode   = 8'h00;
        bus1.keycode   = 8'h00;
        test_reset();
        test_idle_anim();
        test_walk();
        test_right_clamp();
        test_left_clamp();
        test_jump();
        test_reset_mid_jump();
        test_hold_high();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
